// File: rtl/complex_dot_product_row_feeder.sv
// Row-package feeder for the conjugate complex dot-product unit: streams paired packages from two
// single-port memories and returns the unit's result. Optional drain watchdog: FEEDER_TIMEOUT_EN.
module complex_dot_product_row_feeder #(
    parameter int ELEMENT_WIDTH  = 64,
    parameter int NO_OF_UNITS    = 8,
    parameter int ADDR_WIDTH     = 10,
    parameter int HOLD_CYCLES    = 2,   // legal range 1..15
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic                                 start_i,
    input  logic [31:0]                          total_i,
    input  logic [ADDR_WIDTH-1:0]                base_addr_a_i,
    input  logic [ADDR_WIDTH-1:0]                base_addr_b_i,
    output logic                                 mem_a_rd_en_o,
    output logic [ADDR_WIDTH-1:0]                mem_a_addr_o,
    input  logic [ELEMENT_WIDTH*NO_OF_UNITS-1:0] mem_a_rdata_i,
    output logic                                 mem_b_rd_en_o,
    output logic [ADDR_WIDTH-1:0]                mem_b_addr_o,
    input  logic [ELEMENT_WIDTH*NO_OF_UNITS-1:0] mem_b_rdata_i,
    output logic [ELEMENT_WIDTH*NO_OF_UNITS-1:0] first_row_o,
    output logic [ELEMENT_WIDTH*NO_OF_UNITS-1:0] second_row_o,
    output logic                                 read_now_o,
    output logic [31:0]                          dp_total_o,
    output logic                                 dp_reset_o,
    input  logic                                 dp_finish_i,
    input  logic [ELEMENT_WIDTH-1:0]             dp_result_i,
    output logic [ELEMENT_WIDTH-1:0]             result_o,
    output logic                                 busy_o,
    output logic                                 done_o,
    output logic                                 error_o
);

    localparam int ROW_W = ELEMENT_WIDTH * NO_OF_UNITS;
    localparam logic [3:0] HOLD_LAST = 4'(HOLD_CYCLES);
    localparam logic [3:0] HOLD_PRE  = 4'(HOLD_CYCLES - 1);

    typedef enum logic [1:0] {S_IDLE, S_CLEAR, S_STREAM, S_DRAIN} state_t;

    state_t                  state_q, state_d;
    logic [31:0]             pkg_q, pkg_d;
    logic [31:0]             n_q, n_d;
    logic [3:0]              hold_q, hold_d;
    logic [ADDR_WIDTH-1:0]   ptr_a_q, ptr_a_d, ptr_b_q, ptr_b_d;
    logic                    rd_en_q, rd_en_d;
    logic [ADDR_WIDTH-1:0]   addr_a_q, addr_a_d, addr_b_q, addr_b_d;
    logic [ROW_W-1:0]        row_a_q, row_a_d, row_b_q, row_b_d;
    logic                    bypass_q, bypass_d;
    logic                    read_now_q, read_now_d;
    logic [31:0]             dp_total_q, dp_total_d;
    logic                    dp_reset_q, dp_reset_d;
    logic                    finish_mask_q;
    logic [ELEMENT_WIDTH-1:0] result_q, result_d;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;
    logic                    error_q, error_d;
    logic                    start_ok;
    logic                    finish_ok;
`ifdef FEEDER_TIMEOUT_EN
    logic [31:0]             timer_q, timer_d;
`endif

    assign start_ok  = (total_i != 32'd0) && ((total_i % 32'(NO_OF_UNITS)) == 32'd0);
    // The unit's sticky finish is stale until one cycle after dp_reset has dropped.
    assign finish_ok = dp_finish_i && !dp_reset_q && !finish_mask_q;

    always_comb begin
        state_d    = state_q;
        pkg_d      = pkg_q;
        n_d        = n_q;
        hold_d     = hold_q;
        ptr_a_d    = ptr_a_q;
        ptr_b_d    = ptr_b_q;
        rd_en_d    = 1'b0;
        addr_a_d   = addr_a_q;
        addr_b_d   = addr_b_q;
        row_a_d    = row_a_q;
        row_b_d    = row_b_q;
        bypass_d   = 1'b0;
        read_now_d = 1'b0;
        dp_total_d = dp_total_q;
        dp_reset_d = 1'b0;
        result_d   = result_q;
        done_d     = 1'b0;
        error_d    = 1'b0;
`ifdef FEEDER_TIMEOUT_EN
        timer_d    = timer_q;
`endif

        case (state_q)
            S_IDLE: begin
                if (start_i && !done_q) begin
                    if (start_ok) begin
                        state_d    = S_CLEAR;
                        dp_total_d = total_i;
                        n_d        = total_i / 32'(NO_OF_UNITS);
                        dp_reset_d = 1'b1;
                        rd_en_d    = 1'b1;
                        addr_a_d   = base_addr_a_i;
                        addr_b_d   = base_addr_b_i;
                        ptr_a_d    = base_addr_a_i + ADDR_WIDTH'(1);
                        ptr_b_d    = base_addr_b_i + ADDR_WIDTH'(1);
                    end else begin
                        error_d = 1'b1;
                    end
                end
            end
            S_CLEAR: begin
                state_d = S_STREAM;
                pkg_d   = 32'd0;
                hold_d  = 4'd0;
            end
            S_STREAM: begin
                if (hold_q == HOLD_LAST) begin
                    if (pkg_q == n_q - 32'd1) begin
                        state_d = S_DRAIN;
`ifdef FEEDER_TIMEOUT_EN
                        timer_d = 32'd0;
`endif
                    end else begin
                        pkg_d  = pkg_q + 32'd1;
                        hold_d = 4'd0;
                    end
                end else begin
                    hold_d = hold_q + 4'd1;
                end
            end
            S_DRAIN: begin
                if (finish_ok) begin
                    result_d = dp_result_i;
                    done_d   = 1'b1;
                    state_d  = S_IDLE;
                end
`ifdef FEEDER_TIMEOUT_EN
                else if (timer_q == 32'(TIMEOUT_CYCLES - 1)) begin
                    error_d = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    timer_d = timer_q + 32'd1;
                end
`endif
            end
            default: state_d = S_IDLE;
        endcase

        // Strobes and reads are derived from next-cycle counters so the registered outputs line up.
        if (state_d == S_STREAM) begin
            read_now_d = (hold_d == 4'd0);
            bypass_d   = (hold_d == 4'd0) && (pkg_d == 32'd0);
            if ((hold_d == HOLD_PRE) && (pkg_d < n_q - 32'd1)) begin
                rd_en_d  = 1'b1;
                addr_a_d = ptr_a_q;
                addr_b_d = ptr_b_q;
                ptr_a_d  = ptr_a_q + ADDR_WIDTH'(1);
                ptr_b_d  = ptr_b_q + ADDR_WIDTH'(1);
            end
        end

        if (bypass_q || ((state_q == S_STREAM) && (hold_q == HOLD_LAST) && (state_d == S_STREAM))) begin
            row_a_d = mem_a_rdata_i;
            row_b_d = mem_b_rdata_i;
        end
        if (state_d != S_STREAM) begin
            row_a_d = '0;
            row_b_d = '0;
        end

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= S_IDLE;
            pkg_q         <= 32'd0;
            n_q           <= 32'd0;
            hold_q        <= 4'd0;
            ptr_a_q       <= '0;
            ptr_b_q       <= '0;
            rd_en_q       <= 1'b0;
            addr_a_q      <= '0;
            addr_b_q      <= '0;
            row_a_q       <= '0;
            row_b_q       <= '0;
            bypass_q      <= 1'b0;
            read_now_q    <= 1'b0;
            dp_total_q    <= 32'd0;
            dp_reset_q    <= 1'b1;
            finish_mask_q <= 1'b1;
            result_q      <= '0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            error_q       <= 1'b0;
`ifdef FEEDER_TIMEOUT_EN
            timer_q       <= 32'd0;
`endif
        end else begin
            state_q       <= state_d;
            pkg_q         <= pkg_d;
            n_q           <= n_d;
            hold_q        <= hold_d;
            ptr_a_q       <= ptr_a_d;
            ptr_b_q       <= ptr_b_d;
            rd_en_q       <= rd_en_d;
            addr_a_q      <= addr_a_d;
            addr_b_q      <= addr_b_d;
            row_a_q       <= row_a_d;
            row_b_q       <= row_b_d;
            bypass_q      <= bypass_d;
            read_now_q    <= read_now_d;
            dp_total_q    <= dp_total_d;
            dp_reset_q    <= dp_reset_d;
            finish_mask_q <= dp_reset_q;
            result_q      <= result_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            error_q       <= error_d;
`ifdef FEEDER_TIMEOUT_EN
            timer_q       <= timer_d;
`endif
        end
    end

    // Package 0 reaches the rows the cycle its read returns, straight from the memory's output register.
    assign first_row_o   = bypass_q ? mem_a_rdata_i : row_a_q;
    assign second_row_o  = bypass_q ? mem_b_rdata_i : row_b_q;
    assign mem_a_rd_en_o = rd_en_q;
    assign mem_b_rd_en_o = rd_en_q;
    assign mem_a_addr_o  = addr_a_q;
    assign mem_b_addr_o  = addr_b_q;
    assign read_now_o    = read_now_q;
    assign dp_total_o    = dp_total_q;
    assign dp_reset_o    = dp_reset_q;
    assign result_o      = result_q;
    assign busy_o        = busy_q;
    assign done_o        = done_q;
    assign error_o       = error_q;

endmodule

// File: tb/tb_complex_dot_product_row_feeder.sv
// Scoreboard bench for complex_dot_product_row_feeder: memory and dot-product unit models,
// expected reads/packages/results queued at stimulus time and checked by independent monitors.
module tb_complex_dot_product_row_feeder;

    localparam int EW = 64;
    localparam int NU = 8;
    localparam int AW = 10;
    localparam int H  = 2;
    localparam int TO = 16;
    localparam int RW = EW * NU;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          start_i = 1'b0;
    logic [31:0]   total_i = '0;
    logic [AW-1:0] base_a = '0, base_b = '0;
    logic          mem_a_rd_en, mem_b_rd_en;
    logic [AW-1:0] mem_a_addr, mem_b_addr;
    logic [RW-1:0] mem_a_rdata = '0, mem_b_rdata = '0;
    logic [RW-1:0] first_row, second_row;
    logic          read_now, dp_reset, busy, done, error;
    logic [31:0]   dp_total;
    logic          dp_finish = 1'b0;
    logic [EW-1:0] dp_result = '0, result;

    int cyc = 0;
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    complex_dot_product_row_feeder #(
        .ELEMENT_WIDTH(EW), .NO_OF_UNITS(NU), .ADDR_WIDTH(AW),
        .HOLD_CYCLES(H), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk), .reset(reset), .start_i(start_i), .total_i(total_i),
        .base_addr_a_i(base_a), .base_addr_b_i(base_b),
        .mem_a_rd_en_o(mem_a_rd_en), .mem_a_addr_o(mem_a_addr), .mem_a_rdata_i(mem_a_rdata),
        .mem_b_rd_en_o(mem_b_rd_en), .mem_b_addr_o(mem_b_addr), .mem_b_rdata_i(mem_b_rdata),
        .first_row_o(first_row), .second_row_o(second_row), .read_now_o(read_now),
        .dp_total_o(dp_total), .dp_reset_o(dp_reset), .dp_finish_i(dp_finish),
        .dp_result_i(dp_result), .result_o(result), .busy_o(busy), .done_o(done), .error_o(error)
    );

    typedef struct { int t; logic [AW-1:0] a; logic [AW-1:0] b; } rd_t;
    typedef struct { int t; logic [RW-1:0] ra; logic [RW-1:0] rb; } pkg_t;
    typedef struct { logic [EW-1:0] res; logic [31:0] tot; } res_t;

    rd_t  exp_rd[$];
    pkg_t exp_pkg[$];
    res_t exp_res[$];
    int   exp_err[$];

    logic [RW-1:0] mem_a [1<<AW];
    logic [RW-1:0] mem_b [1<<AW];

    task automatic chk(input string name, input logic [RW-1:0] act, input logic [RW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h cycle=%0d", name, act, exp, cyc);
        end
    endtask

    // Single-port memories with a registered read port; rdata holds between reads.
    rd_t rd_e;
    always @(posedge clk) begin
        if (mem_a_rd_en) mem_a_rdata <= mem_a[mem_a_addr];
        if (mem_b_rd_en) mem_b_rdata <= mem_b[mem_b_addr];
        if (mem_a_rd_en || mem_b_rd_en) begin
            if (exp_rd.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected_read actual=%0h/%0h required=none cycle=%0d", mem_a_addr, mem_b_addr, cyc);
            end else begin
                rd_e = exp_rd.pop_front();
                chk("rd_en_pair", {mem_a_rd_en, mem_b_rd_en}, 2'b11);
                chk("rd_addr_a", mem_a_addr, rd_e.a);
                chk("rd_addr_b", mem_b_addr, rd_e.b);
                chk("rd_cycle", cyc, rd_e.t);
            end
        end
    end

    // Dot-product unit model: raises a sticky finish some cycles after the last package.
    int            u_strobes = 0;
    int            u_cnt = -1;
    int            cur_n = 0;
    logic [EW-1:0] cur_result = '0;
    bit            no_finish = 1'b0;
    always @(negedge clk) begin
        if (reset || dp_reset) begin
            u_strobes = 0;
            u_cnt     = -1;
            dp_finish = 1'b0;
        end else begin
            if (read_now) begin
                u_strobes++;
                if (u_strobes == cur_n && !no_finish) u_cnt = H + 1 + $urandom_range(0, 4);
            end else if (u_cnt > 0) begin
                u_cnt--;
            end
            if (u_cnt == 0) begin
                dp_finish = 1'b1;
                dp_result = cur_result;
                u_cnt     = -1;
            end
        end
        if (!dp_finish) dp_result = {$urandom, $urandom};
    end

    // Monitor: compares every strobe, hold cycle, done and error against the queues.
    int            hold_left = 0;
    logic [RW-1:0] held_a, held_b;
    pkg_t          pk_e;
    res_t          rs_e;
    int            er_e;
    always begin
        @(posedge clk);
        #1;
        if (reset) begin
            hold_left = 0;
        end else begin
            if (hold_left > 0) begin
                chk("row_a_stable", first_row, held_a);
                chk("row_b_stable", second_row, held_b);
                hold_left--;
            end
            if (read_now) begin
                if (exp_pkg.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_read_now actual=1 required=0 cycle=%0d", cyc);
                end else begin
                    pk_e = exp_pkg.pop_front();
                    chk("strobe_cycle", cyc, pk_e.t);
                    chk("first_row", first_row, pk_e.ra);
                    chk("second_row", second_row, pk_e.rb);
                end
                held_a    = first_row;
                held_b    = second_row;
                hold_left = H;
            end
            if (done) begin
                if (exp_res.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_done actual=1 required=0 cycle=%0d", cyc);
                end else begin
                    rs_e = exp_res.pop_front();
                    chk("result", result, rs_e.res);
                    chk("dp_total", dp_total, rs_e.tot);
                    chk("busy_at_done", busy, 1'b0);
                end
            end
            if (error) begin
                if (exp_err.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_error actual=1 required=0 cycle=%0d", cyc);
                end else begin
                    er_e = exp_err.pop_front();
                    chk("error_cycle", cyc, er_e);
                end
            end
        end
    end

    task automatic flush_queues();
        exp_rd.delete();
        exp_pkg.delete();
        exp_res.delete();
        exp_err.delete();
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_rd_en"}, {mem_a_rd_en, mem_b_rd_en}, 2'b00);
        chk({tag, "_addr"}, {mem_a_addr, mem_b_addr}, '0);
        chk({tag, "_rows"}, first_row | second_row, '0);
        chk({tag, "_strobes"}, {read_now, busy, done, error}, 4'b0000);
        chk({tag, "_dp_total"}, dp_total, 32'd0);
        chk({tag, "_result"}, result, '0);
        chk({tag, "_dp_reset"}, dp_reset, 1'b1);
    endtask

    task automatic run_txn(input int total, input logic [AW-1:0] ba, input logic [AW-1:0] bb,
                           input logic [EW-1:0] res, input bit mid_start, input bit mid_reset,
                           input bit coincide, input bit nofin);
        int c, n, drain_t;
        bit valid, fin, co_done;
        @(negedge clk);
        c     = cyc;
        valid = (total != 0) && (total % NU == 0);
        n     = total / NU;
        $display("txn cycle=%0d total=%0d base_a=%0h base_b=%0h valid=%0d", c, total, ba, bb, valid);
        start_i = 1'b1;
        total_i = total;
        base_a  = ba;
        base_b  = bb;
        if (valid) begin
            cur_n      = n;
            cur_result = res;
            no_finish  = nofin;
            for (int k = 0; k < n; k++) begin
                exp_pkg.push_back('{c + 2 + k*(H+1), mem_a[AW'(ba + k)], mem_b[AW'(bb + k)]});
                exp_rd.push_back('{(k == 0) ? c + 1 : c + 2 + (k-1)*(H+1) + H - 1, AW'(ba + k), AW'(bb + k)});
            end
            drain_t = c + 2 + (n-1)*(H+1) + H + 1;
            if (nofin) exp_err.push_back(drain_t + TO);
            else if (!mid_reset) exp_res.push_back('{res, total});
        end else begin
            exp_err.push_back(c + 1);
        end
        @(negedge clk);
        start_i = 1'b0;
        total_i = $urandom;
        if (!valid) chk("busy_after_reject", busy, 1'b0);
        fin     = 1'b0;
        co_done = 1'b0;
        for (int i = 0; i < 2000 && !fin; i++) begin
            @(negedge clk);
            start_i = 1'b0;
            if (mid_start && cyc == c + 3) begin
                start_i = 1'b1;
                total_i = 16;
                base_a  = AW'($urandom);
                base_b  = AW'($urandom);
            end
            if (mid_reset && cyc == c + 6) reset = 1'b1;
            if (mid_reset && cyc == c + 7) begin
                check_reset_outputs("midreset");
                reset = 1'b0;
                flush_queues();
            end
            if (coincide && done && !co_done) begin
                start_i = 1'b1;
                total_i = 8;
                co_done = 1'b1;
            end
            if (!start_i && !reset && busy == 1'b0 && cyc > c + 1 &&
                exp_rd.size() == 0 && exp_pkg.size() == 0 && exp_res.size() == 0 && exp_err.size() == 0)
                fin = 1'b1;
        end
        if (!fin) begin
            checks++; errors++;
            $display("FAIL txn_timeout actual=busy:%0d required=idle cycle=%0d", busy, cyc);
            flush_queues();
            reset = 1'b1;
            repeat (2) @(negedge clk);
            reset = 1'b0;
        end
        if (coincide) begin
            @(negedge clk);
            chk("coincide_start_ignored", busy, 1'b0);
        end
    endtask

    initial begin
        for (int i = 0; i < (1<<AW); i++) begin
            for (int w = 0; w < RW/32; w++) begin
                mem_a[i][w*32 +: 32] = $urandom;
                mem_b[i][w*32 +: 32] = $urandom;
            end
        end
        reset = 1'b1;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        reset = 1'b0;
        repeat (2) @(negedge clk);

        run_txn(8,  10'h010, 10'h200, 64'hA5, 0, 0, 0, 0);
        run_txn(32, 10'h010, 10'h200, {$urandom, $urandom}, 0, 0, 0, 0);
        run_txn(0,  10'h010, 10'h200, '0, 0, 0, 0, 0);
        run_txn(12, 10'h010, 10'h200, '0, 0, 0, 0, 0);
        run_txn(32, 10'h010, 10'h200, {$urandom, $urandom}, 1, 0, 0, 0);
        run_txn(32, 10'h010, 10'h200, {$urandom, $urandom}, 0, 1, 0, 0);
        run_txn(16, 10'h010, 10'h200, {$urandom, $urandom}, 0, 0, 1, 0);
        run_txn(32, 10'h3FE, 10'h3FF, {$urandom, $urandom}, 0, 0, 0, 0);
`ifdef FEEDER_TIMEOUT_EN
        run_txn(16, 10'h010, 10'h200, {$urandom, $urandom}, 0, 0, 0, 1);
`endif
        for (int i = 0; i < 24; i++) begin
            int t;
            if ($urandom_range(0, 4) == 0)
                t = ($urandom_range(0, 3) == 0) ? 0 : NU * $urandom_range(0, 4) + $urandom_range(1, NU-1);
            else
                t = NU * $urandom_range(1, 6);
            run_txn(t, AW'($urandom), AW'($urandom), {$urandom, $urandom}, 0, 0, (i % 4) == 3, 0);
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end

        repeat (4) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
